compare_unit_pipe: RTL and testbench
====================================

// Module: compare_unit_pipe
// PURPOSE
//  Parametrised, pipelined successor of the datapath comparator. Accepts {a, b, op, tag} under a
//  valid/ready handshake and evaluates the compare (signed or unsigned) at acceptance.
//  Queues the 1-bit result with its tag in a 2-entry output buffer.
//  Keeps a saturating count of true results delivered. Sits between decode/issue and branch resolution.
// PARAMETERS
//  WIDTH    32  operand width in bits (>=2)
//  TAG_W     4  width of sideband tag carried with each request
//  COUNT_W  16  width of true-result counter
// PORTS
//  clock          in   1        rising-edge clock
//  reset          in   1        synchronous, active-high reset
//  in_valid       in   1        request valid
//  in_ready       out  1        request can be accepted this cycle
//  in_a           in   WIDTH    operand a
//  in_b           in   WIDTH    operand b
//  in_op          in   4        [2:0] compare code, [3] 1=signed (two's complement), 0=unsigned
//  in_tag         in   TAG_W    sideband, returned unchanged with result
//  out_valid      out  1        result valid
//  out_ready      in   1        consumer accepts result
//  out_compout    out  1        compare result
//  out_bad_op     out  1        1 when op[2:0] was 110 or 111
//  out_tag        out  TAG_W    tag of the request that produced this result
//  clear_count    in   1        synchronous clear of true_count
//  true_count     out  COUNT_W  number of popped results with out_compout=1 (saturating)
// BEHAVIOUR
//  Compare codes op[2:0]: 000 a==b, 001 a>=b, 010 a<=b, 011 a>b, 100 a<b, 101 a!=b.
//  - Codes 110/111: compout=0, bad_op=1; the entry is still queued and popped normally.
//  - op[3] affects ordering codes only; ==/!= are identical signed/unsigned.
//  Accept (push) = in_valid & in_ready; deliver (pop) = out_valid & out_ready.
//  - Result is computed from in_* in the push cycle and stored; in_* are not sampled afterwards.
//  Buffer: 2-entry FIFO, occupancy 0..2, strict FIFO order.
//  - in_ready = (occupancy < 2), registered-state only; in_ready has no combinational path from out_ready.
//  - out_valid = (occupancy > 0). out_compout/out_bad_op/out_tag come from the head entry.
//  - All three drive 0 when the buffer is empty.
//  Latency: push in cycle N into an empty buffer -> out_valid=1 in cycle N+1. Throughput: 1 result/cycle
//  when out_ready is held 1.
//  Simultaneous push and pop (occupancy 1): occupancy stays 1 and the new entry becomes head next cycle.
//  - At occupancy 2 no push can occur; a pop drops occupancy to 1 and in_ready rises the next cycle.
//  Full: in_ready=0, in_valid ignored, no data lost. Empty: out_ready ignored.
//  Counter: on a pop with out_compout=1, true_count+1, saturating at 2^COUNT_W-1 (no wrap).
//  - clear_count sets true_count=0 next cycle; clear wins over a simultaneous increment.
//  Reset (any cycle, including mid-transfer): occupancy=0, all entries discarded, true_count=0.
//  - Outputs after reset: in_ready=1, out_valid=0, out_compout=0, out_bad_op=0, out_tag=0, true_count=0.
//  - The reset cycle performs no push or pop.
//  Width rules: unsigned compare is zero-extended WIDTH-bit; signed compare uses in_a/in_b as
//  two's complement with MSB as sign bit.
// TESTING
//  1 Reset then idle: in_ready=1, out_valid=0, all outputs 0, true_count=0.
//  2 WIDTH=32, push a=5,b=5, op=0000, tag=3 with out_ready=1 -> next cycle out_valid=1, compout=1,
//    tag=3; true_count=1 the cycle after the pop.
//  3 Signedness: a=32'hFFFF_FFFF, b=1.
//    - op=0011 (unsigned >) -> compout=1.
//    - op=1011 (signed >) -> compout=0.
//    - op=1100 (signed <) -> compout=1.
//  4 Backpressure: out_ready=0, push 3 requests (tags 1,2,3).
//    - Tags 1 and 2 accepted; in_ready=0 while tag 3 is held.
//    - Raise out_ready: tags pop in order 1,2,3 with no loss or duplication.
//  5 Bad op: op=0110, a=0, b=0 -> compout=0, bad_op=1, entry popped, true_count unchanged.
//  6 Counter: COUNT_W=2, pop 5 true results -> true_count saturates at 3.
//    - clear_count asserted in the same cycle as a true pop -> true_count=0.
//    - Reset asserted with 2 entries queued -> out_valid=0 next cycle and the entries are never delivered.

Source files
------------

// File: rtl/compare_unit_pipe.sv
// Pipelined datapath comparator: evaluates a signed/unsigned compare at acceptance,
// queues {result, bad_op, tag} in a 2-entry FIFO and counts delivered true results.

module compare_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             res,
    output logic             bad
);
    logic [WIDTH-1:0] ax, bx;
    logic             eq, lt, gt;

    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign ax = {a[WIDTH-1] ^ op[3], a[WIDTH-2:0]};
    assign bx = {b[WIDTH-1] ^ op[3], b[WIDTH-2:0]};
    assign eq = (a == b);
    assign lt = (ax < bx);
    assign gt = !lt && !eq;

    always_comb begin
        res = 1'b0;
        bad = 1'b0;
        case (op[2:0])
            3'b000:  res = eq;
            3'b001:  res = !lt;
            3'b010:  res = !gt;
            3'b011:  res = gt;
            3'b100:  res = lt;
            3'b101:  res = !eq;
            default: bad = 1'b1;
        endcase
    end
endmodule

module compare_unit_pipe #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [3:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_compout,
    output logic               out_bad_op,
    output logic [TAG_W-1:0]   out_tag,
    input  logic               clear_count,
    output logic [COUNT_W-1:0] true_count
);
    typedef struct packed {
        logic             res;
        logic             bad;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t     mem [2];
    entry_t     new_ent, head;
    logic       wr_ptr, rd_ptr;
    logic [1:0] occ;
    logic       push, pop;
    logic       cmp_res, cmp_bad;

    compare_core #(.WIDTH(WIDTH)) u_core (
        .a   (in_a),
        .b   (in_b),
        .op  (in_op),
        .res (cmp_res),
        .bad (cmp_bad)
    );

    assign new_ent = '{res: cmp_res, bad: cmp_bad, tag: in_tag};

    // Ready depends only on occupancy, so there is no path from out_ready.
    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = out_valid ? mem[rd_ptr] : '0;

    assign out_compout = head.res;
    assign out_bad_op  = head.bad;
    assign out_tag     = head.tag;

    always_ff @(posedge clock) begin
        if (reset) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_ent;
                wr_ptr      <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clock) begin
        if (reset || clear_count)
            true_count <= '0;
        else if (pop && head.res && (true_count != {COUNT_W{1'b1}}))
            true_count <= true_count + 1'b1;
    end
endmodule

// File: tb/tb_compare_unit_pipe.sv
// Directed bench for compare_unit_pipe (WIDTH=32, TAG_W=4, COUNT_W=2).

module tb_compare_unit_pipe;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic        out_compout;
    logic        out_bad_op;
    logic [3:0]  out_tag;
    logic        clear_count;
    logic [1:0]  true_count;

    int checks = 0;
    int errors = 0;

    compare_unit_pipe #(.WIDTH(32), .TAG_W(4), .COUNT_W(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_compout (out_compout),
        .out_bad_op  (out_bad_op),
        .out_tag     (out_tag),
        .clear_count (clear_count),
        .true_count  (true_count)
    );

    always #5 clock = !clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [3:0] tag);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
    endtask

    // One request into an empty buffer with out_ready=1: check it, then let it pop.
    task automatic one_shot(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic expres);
        drive(1'b1, a, b, op, 4'd0);
        step();
        in_valid = 1'b0;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_res"}, 32'(out_compout), 32'(expres));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; out_ready = 1'b0; clear_count = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        step(); step();
        reset = 1'b0;
        step();
        // 1: reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_compout", 32'(out_compout), 32'd0);
        chk("rst_bad_op", 32'(out_bad_op), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_count", 32'(true_count), 32'd0);

        // 2: basic equal, latency 1
        out_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd5, 4'b0000, 4'd3);
        step();
        in_valid = 1'b0;
        chk("eq_valid", 32'(out_valid), 32'd1);
        chk("eq_res", 32'(out_compout), 32'd1);
        chk("eq_tag", 32'(out_tag), 32'd3);
        chk("eq_count_before", 32'(true_count), 32'd0);
        step();
        chk("eq_count_after", 32'(true_count), 32'd1);
        chk("eq_empty", 32'(out_valid), 32'd0);

        // 3: signedness and remaining codes
        one_shot("ugt", 32'hFFFF_FFFF, 32'd1, 4'b0011, 1'b1);
        one_shot("sgt", 32'hFFFF_FFFF, 32'd1, 4'b1011, 1'b0);
        one_shot("slt", 32'hFFFF_FFFF, 32'd1, 4'b1100, 1'b1);
        one_shot("ult", 32'hFFFF_FFFF, 32'd1, 4'b0100, 1'b0);
        one_shot("sge", 32'h8000_0000, 32'h7FFF_FFFF, 4'b1001, 1'b0);
        one_shot("ule", 32'd7, 32'd7, 4'b0010, 1'b1);
        one_shot("sne", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1101, 1'b0);
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        chk("clr_count", 32'(true_count), 32'd0);

        // 4: backpressure, order preserved (all results false)
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd2, 4'b0000, 4'd1);
        step();
        drive(1'b1, 32'd1, 32'd2, 4'b0000, 4'd2);
        step();
        drive(1'b1, 32'd1, 32'd2, 4'b0000, 4'd3);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        step();
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        chk("bp_head1", 32'(out_tag), 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_head2", 32'(out_tag), 32'd2);
        step();
        in_valid = 1'b0;
        chk("bp_head3", 32'(out_tag), 32'd3);
        chk("bp_valid3", 32'(out_valid), 32'd1);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(true_count), 32'd0);

        // 5: bad op
        drive(1'b1, 32'd0, 32'd0, 4'b0110, 4'd9);
        step();
        in_valid = 1'b0;
        chk("bad_valid", 32'(out_valid), 32'd1);
        chk("bad_res", 32'(out_compout), 32'd0);
        chk("bad_flag", 32'(out_bad_op), 32'd1);
        chk("bad_tag", 32'(out_tag), 32'd9);
        step();
        chk("bad_popped", 32'(out_valid), 32'd0);
        chk("bad_count", 32'(true_count), 32'd0);

        // 6: saturation with streaming at full throughput
        drive(1'b1, 32'd4, 32'd4, 4'b0000, 4'd0);
        step();
        for (int i = 1; i < 5; i++) begin
            in_tag = 4'(i);
            chk("sat_stream_valid", 32'(out_valid), 32'd1);
            chk("sat_stream_tag", 32'(out_tag), 32'(i - 1));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("sat_count", 32'(true_count), 32'd3);
        chk("sat_empty", 32'(out_valid), 32'd0);
        step();
        chk("sat_hold", 32'(true_count), 32'd3);

        // clear beats simultaneous true pop
        drive(1'b1, 32'd4, 32'd4, 4'b0000, 4'd0);
        step();
        in_valid = 1'b0;
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        chk("clr_vs_pop", 32'(true_count), 32'd0);

        // reset with 2 entries queued
        out_ready = 1'b0;
        drive(1'b1, 32'd4, 32'd4, 4'b0000, 4'd5);
        step();
        in_tag = 4'd6;
        step();
        in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step(); step();
        chk("mid_rst_gone", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(true_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
